fifo_stream_reader: RTL

Downstream drain stage for the synchronous FIFO. It issues `fifo_rd_en` only while a slot is free, captures `fifo_dout` one cycle after each read, and presents the words in order on a valid/ready stream through a 2-entry output buffer. It sustains one word per cycle. It also provides an enable/drain handshake, a delivered-word counter and a sticky underflow error flag.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_out_buf.sv | 63 ++++++
 rtl/fifo_stream_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain stage.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // True when a new read still fits in the output buffer, counting the
    // word already in flight and crediting back a word popped this cycle.
    function automatic logic has_credit(input logic [1:0] occ,
                                        input logic       infl,
                                        input logic       pop);
        logic [2:0] used_s;
        used_s = {1'b0, occ} + {2'b00, infl};
        return used_s < (3'(BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order register buffer; slot0 is always the head.
import fifo_pkg::*;

module fifo_out_buf #(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0_r;
    logic [WIDTH-1:0] slot1_r;
    logic [1:0]       occ_r;
    logic             pop_s;
    logic             push_s;

    // An empty buffer cannot pop; a full one accepts a push only if it pops too.
    assign pop_s  = pop && (occ_r != 2'd0);
    assign push_s = push && ((occ_r != 2'(BUF_DEPTH)) || pop_s);

    // Shift/append storage so that words always leave in arrival order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_r <= '0;
            slot1_r <= '0;
            occ_r   <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b01: begin
                    slot0_r <= slot1_r;
                    occ_r   <= occ_r - 2'd1;
                end
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        slot0_r <= data;
                    end else begin
                        slot1_r <= data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        slot0_r <= data;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign occ  = occ_r;
    assign head = slot0_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream at one word per cycle.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  underflow_err
);

    import fifo_pkg::*;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  infl_r;
    logic [CNT_WIDTH-1:0]  words_r;
    logic                  err_r;
    logic [1:0]            occ_s;
    logic [FIFO_WIDTH-1:0] head_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  rd_en_s;

    assign valid_s = (occ_s != 2'd0);
    assign pop_s   = valid_s && m_ready;

    // Reads are only issued while running and a buffer slot is guaranteed.
    assign rd_en_s = rst_n && (state_r == RUN) && !fifo_empty &&
                     has_credit(occ_s, infl_r, pop_s);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= STOPPED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Run/drain/stop transitions; DRAIN waits for the buffer and the in-flight read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            STOPPED: begin
                if (en) state_nxt_s = RUN;
                else    state_nxt_s = STOPPED;
            end
            RUN: begin
                if (!en) state_nxt_s = DRAIN;
                else     state_nxt_s = RUN;
            end
            DRAIN: begin
                if (en)                                  state_nxt_s = RUN;
                else if ((occ_s == 2'd0) && !infl_r)     state_nxt_s = STOPPED;
                else                                     state_nxt_s = DRAIN;
            end
            default: state_nxt_s = STOPPED;
        endcase
    end

    // In-flight read tracking, delivered-word counter and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            infl_r  <= 1'b0;
            words_r <= '0;
            err_r   <= 1'b0;
        end else begin
            infl_r <= rd_en_s;
            if (pop_s) begin
                words_r <= words_r + CNT_WIDTH'(1);
            end
            if (fifo_underflow) begin
                err_r <= 1'b1;
            end
        end
    end

    // Word read last cycle is valid on fifo_dout now and lands at the tail.
    fifo_out_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (infl_r),
        .data  (fifo_dout),
        .pop   (pop_s),
        .occ   (occ_s),
        .head  (head_s)
    );

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = valid_s;
    assign m_data        = head_s;
    assign idle          = (state_r == STOPPED);
    assign words_out     = words_r;
    assign underflow_err = err_r;

endmodule
